// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// default latencies, FSM state type and a small decode helper.
package muldiv_ctrl_pkg;

    // E-stage multiply/divide op encoding; 7 is reserved and behaves as NONE
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    // Default fixed latencies modelled for the multiplier and divider
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Sequencer states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // True for the ops that occupy the unit for several cycles
    function automatic logic is_muldiv(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the multiply flavours (selects the shorter latency)
    function automatic logic is_mult(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle between the execute stage and the multiply/divide sequencer.
// The execute stage is the master (drives op and operands); the sequencer
// is the slave (returns start/busy to the stall unit and the HI/LO values).
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    md_op_e      md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_op,
        output rs_val,
        output rt_val,
        input  start,
        input  busy,
        input  hi,
        input  lo
    );

    modport slave (
        input  md_op,
        input  rs_val,
        input  rt_val,
        output start,
        output busy,
        output hi,
        output lo
    );

endinterface

// File: rtl/muldiv_alu.sv
// Combinational multiply/divide datapath. Produces the full 64-bit
// {HI, LO} result for the op presented, plus a flag for a zero divisor.
// Signed division runs on magnitudes and fixes up signs afterwards so a
// single unsigned divider serves both DIV and DIVU.
module muldiv_alu
    import muldiv_ctrl_pkg::*;
(
    input  md_op_e      md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [63:0] result,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] div_den;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Compute both products and the sign-corrected quotient/remainder, then pick by op
    always_comb begin
        prod_s     = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        prod_u     = {32'd0, rs_val} * {32'd0, rt_val};

        signed_div = (md_op == MD_DIV);
        rs_mag     = (signed_div && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
        rt_mag     = (signed_div && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
        div_den    = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
        quot_mag   = rs_mag / div_den;
        rem_mag    = rs_mag % div_den;
        quot       = (signed_div && (rs_val[31] ^ rt_val[31])) ? (32'd0 - quot_mag) : quot_mag;
        rem        = (signed_div && rs_val[31]) ? (32'd0 - rem_mag) : rem_mag;

        div_zero   = ((md_op == MD_DIV) || (md_op == MD_DIVU)) && (rt_val == 32'd0);

        case (md_op)
            MD_MULT:         result = prod_s;
            MD_MULTU:        result = prod_u;
            MD_DIV, MD_DIVU: result = {rem, quot};
            default:         result = 64'd0;
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for the E stage. Owns HI/LO, accepts a
// mult/div op while idle, holds its result for a fixed latency and then
// commits it. MTHI/MTLO write HI/LO directly on the next edge. A divide
// by zero runs the full latency but leaves HI/LO untouched.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_ctrl_if.slave      mif
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        res_hi_q, res_hi_d;
    logic [31:0]        res_lo_q, res_lo_d;
    logic               zero_q, zero_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               start_raw;

    logic [63:0]        alu_result;
    logic               alu_div_zero;

    muldiv_alu u_alu (
        .md_op    (mif.md_op),
        .rs_val   (mif.rs_val),
        .rt_val   (mif.rt_val),
        .result   (alu_result),
        .div_zero (alu_div_zero)
    );

    // Next-state, counter, result latch and HI/LO update decisions
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        zero_d    = zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        start_raw = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_muldiv(mif.md_op)) begin
                    start_raw = 1'b1;
                    res_hi_d  = alu_result[63:32];
                    res_lo_d  = alu_result[31:0];
                    zero_d    = alu_div_zero;
                    cnt_d     = is_mult(mif.md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_d   = ST_RUN;
                end else if (mif.md_op == MD_MTHI) begin
                    hi_d = mif.rs_val;
                end else if (mif.md_op == MD_MTLO) begin
                    lo_d = mif.rs_val;
                end
            end
            ST_RUN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    if (!zero_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset clears everything, discarding any in-flight result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            zero_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign mif.start = start_raw & ~reset;
    assign mif.busy  = (state_q == ST_RUN);
    assign mif.hi    = hi_q;
    assign mif.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: a cycle-level behavioural model
// (wide integer arithmetic plus a remaining-busy-cycles count) is checked
// against the DUT every cycle, with directed scenarios pinned by literal
// expectations and a randomized tail.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic clk;
    logic reset;

    muldiv_ctrl_if mif ();

    muldiv_ctrl #(
        .MULT_CYCLES (N_MULT),
        .DIV_CYCLES  (N_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;
    logic [31:0] m_res_hi = 32'd0;
    logic [31:0] m_res_lo = 32'd0;
    logic        m_zero   = 1'b0;
    int          m_remain = 0;

    logic [31:0] specials [5];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if the run ever wanders off
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    // The stall unit never presents an op while the unit is busy
    always @(negedge clk) begin
        if (!reset && mif.busy === 1'b1)
            assert (mif.md_op == MD_NONE) else $error("[TB] op presented while busy");
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference result from plain wide arithmetic: {div_zero, hi, lo}
    function automatic logic [64:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        logic [31:0] uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                p = 64'(sa * sb);
                return {1'b0, p};
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            3'd3: begin
                if (b == 32'd0) return {1'b1, 64'd0};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {1'b1, 64'd0};
                uq = a / b;
                ur = a % b;
                return {1'b0, ur, uq};
            end
            default: return 65'd0;
        endcase
    endfunction

    // Every-cycle comparison of DUT outputs against the model
    task automatic checkOutput();
        logic [2:0] opv;
        logic       exp_start;
        opv       = mif.md_op;
        exp_start = !reset && (m_remain == 0) && (opv >= 3'd1) && (opv <= 3'd4);
        compare("start", 32'(mif.start), 32'(exp_start));
        compare("busy",  32'(mif.busy),  32'(m_remain > 0));
        compare("hi",    mif.hi, m_hi);
        compare("lo",    mif.lo, m_lo);
    endtask

    // Advance the model across one rising edge using the inputs seen there
    task automatic modelStep();
        logic [2:0]  opv;
        logic [64:0] r;
        opv = mif.md_op;
        if (reset) begin
            m_hi     = 32'd0;
            m_lo     = 32'd0;
            m_remain = 0;
        end else if (m_remain > 0) begin
            m_remain--;
            if (m_remain == 0 && !m_zero) begin
                m_hi = m_res_hi;
                m_lo = m_res_lo;
            end
        end else begin
            case (opv)
                3'd1, 3'd2, 3'd3, 3'd4: begin
                    r        = refResult(opv, mif.rs_val, mif.rt_val);
                    m_zero   = r[64];
                    m_res_hi = r[63:32];
                    m_res_lo = r[31:0];
                    m_remain = (opv <= 3'd2) ? N_MULT : N_DIV;
                end
                3'd5: m_hi = mif.rs_val;
                3'd6: m_lo = mif.rs_val;
                default: ;
            endcase
        end
    endtask

    // Drive one cycle of inputs, check at negedge, update the model at posedge
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                 output logic st, output logic bz);
        mif.md_op  = md_op_e'(op);
        mif.rs_val = rs;
        mif.rt_val = rt;
        @(negedge clk);
        st = mif.start;
        bz = mif.busy;
        checkOutput();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    // Issue one mult/div, idle through it with scrambled operands, pin the outcome
    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_n);
        logic st, bz;
        int   n, guard;
        applyStimulus(op, rs, rt, st, bz);
        compare({name, "_start"}, 32'(st), 32'd1);
        n     = 0;
        guard = 0;
        while (m_remain > 0 && guard < 64) begin
            applyStimulus(3'd0, $urandom, $urandom, st, bz);
            if (bz) n++;
            guard++;
        end
        compare({name, "_busy_cycles"}, 32'(n), 32'(exp_n));
        compare({name, "_busy_end"}, 32'(mif.busy), 32'd0);
        compare({name, "_hi"}, mif.hi, exp_hi);
        compare({name, "_lo"}, mif.lo, exp_lo);
    endtask

    function automatic logic [31:0] pickOperand();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic st, bz;
        logic [2:0] op;

        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;

        reset      = 1'b1;
        mif.md_op  = MD_NONE;
        mif.rs_val = 32'd0;
        mif.rt_val = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // start must stay low while reset is held, even with a MULT presented
        applyStimulus(3'd1, 32'd6, 32'd7, st, bz);
        compare("reset_start", 32'(st), 32'd0);
        reset = 1'b0;
        compare("reset_busy", 32'(mif.busy), 32'd0);
        compare("reset_hi", mif.hi, 32'd0);
        compare("reset_lo", mif.lo, 32'd0);

        runOp("mult",  3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, N_MULT);
        runOp("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, N_MULT);
        runOp("div",   3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, N_DIV);
        runOp("divu",  3'd4, 32'd7,         32'd2, 32'd1,         32'd3,         N_DIV);

        // MTHI then MTLO on consecutive cycles: no busy, visible next cycle
        applyStimulus(3'd5, 32'h1234_5678, 32'd0, st, bz);
        compare("mthi_busy", 32'(bz), 32'd0);
        compare("mthi_hi", mif.hi, 32'h1234_5678);
        applyStimulus(3'd6, 32'h9ABC_DEF0, 32'd0, st, bz);
        compare("mtlo_busy", 32'(bz), 32'd0);
        compare("mtlo_lo", mif.lo, 32'h9ABC_DEF0);
        compare("mtlo_busy_after", 32'(mif.busy), 32'd0);

        runOp("divu_zero", 3'd4, 32'hDEAD_BEEF, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, N_DIV);
        runOp("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, N_DIV);
        // Issued in the very cycle busy drops: back-to-back acceptance
        runOp("mult_b2b",  3'd1, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, N_MULT);

        // Reset in the third busy cycle of a DIV discards the result
        applyStimulus(3'd3, 32'd100, 32'd7, st, bz);
        applyStimulus(3'd0, 32'd0, 32'd0, st, bz);
        applyStimulus(3'd0, 32'd0, 32'd0, st, bz);
        reset = 1'b1;
        applyStimulus(3'd0, 32'd0, 32'd0, st, bz);
        compare("rst_run_busy_cycle3", 32'(bz), 32'd1);
        reset = 1'b0;
        compare("rst_run_busy", 32'(mif.busy), 32'd0);
        compare("rst_run_hi", mif.hi, 32'd0);
        compare("rst_run_lo", mif.lo, 32'd0);
        for (int i = 0; i < 12; i++) applyStimulus(3'd0, $urandom, $urandom, st, bz);
        compare("rst_run_late_hi", mif.hi, 32'd0);
        compare("rst_run_late_lo", mif.lo, 32'd0);

        // Randomized traffic respecting the stall-unit contract
        for (int i = 0; i < 1500; i++) begin
            op = (m_remain == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            applyStimulus(op, pickOperand(), pickOperand(), st, bz);
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multiply/divide sequencer for the E stage: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage, owns the HI/LO registers, and models fixed multi-cycle latency. Drives `start` and `busy` into the stall unit, which holds any HI/LO-touching instruction in D while either is high. MFHI/MFLO read `hi`/`lo` directly.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (≥1).

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high; one clock clears all state.
- `md_op`  in  3  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- `rs_val`  in  32  forwarded rs operand (dividend / multiplicand / MT source).
- `rt_val`  in  32  forwarded rt operand (divisor / multiplier).
- `start`  out  1  combinational; high in the cycle a mult/div op is accepted.
- `busy`  out  1  registered; high while an operation is in flight.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- FSM states: IDLE, RUN. Down-counter `cnt` (width fits max(MULT_CYCLES, DIV_CYCLES)).
- IDLE, `md_op` ∈ {1..4}: `start`=1; latch 64-bit result from sub-module into `res_hi/res_lo`; load `cnt` with MULT_CYCLES or DIV_CYCLES; go RUN.
- IDLE, `md_op`=5: `hi`←`rs_val` at edge. `md_op`=6: `lo`←`rs_val`. `start` stays 0; no busy.
- RUN: `busy`=1; decrement `cnt`; when `cnt`=1 at an edge, commit `hi`←`res_hi`, `lo`←`res_lo`, go IDLE.
- RUN, `md_op`≠NONE: ignored (stall unit guarantees this never occurs; bench asserts on it).
- Arithmetic: MULT signed 32×32→64, MULTU unsigned; HI = upper 32, LO = lower 32.
- DIV signed: quotient truncates toward zero → LO; remainder carries dividend's sign → HI. DIVU unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divisor 0 (DIV or DIVU): full latency runs, HI and LO left unchanged at commit.
- `start` is gated off during RUN and during `reset`.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0; `start`=0 while `reset`=1.
- Op accepted in cycle T: `start`=1 in T; `busy`=1 cycles T+1..T+N (N = MULT_CYCLES or DIV_CYCLES); new `hi`/`lo` visible from T+N+1, same cycle `busy` returns 0.
- Back-to-back: an op presented in T+N+1 is accepted (state is IDLE).
- MTHI/MTLO in T: new value visible T+1.
- Reset during RUN: in-flight result discarded, `hi`/`lo` cleared, `busy` 0 next cycle.
- Operands sampled only in the accept cycle; changes to `rs_val`/`rt_val` during RUN have no effect.

## Structure
- Shared define file: `md_op` encodings (MD_NONE…MD_MTLO), default latency constants.
- One sub-module `muldiv_alu`: combinational, `md_op`/`rs_val`/`rt_val` in, 64-bit `{res_hi,res_lo}` and `div_zero` flag out. `muldiv_ctrl` holds FSM, counter, HI/LO.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3 → `start` 1 cycle, `busy` 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=−7 (0xFFFFFFF9), rt=2 → busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 → lo=3, hi=1.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → hi/lo update next cycle each, `busy` never high; then DIVU x/0 → after 10 cycles hi/lo unchanged.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0; MULT issued in first cycle `busy` drops → accepted, `start`=1.
- Reset asserted in 3rd busy cycle of a DIV → next cycle busy=0, hi=lo=0, no later commit; rs/rt toggled during RUN of a MULT do not alter the result.
